// File: rtl/reg_file_wb.sv
// 32 x 32-bit register file with write-through read ports
// and a pending-write scoreboard for decode hazard detection.
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [CNT_W-1:0]  busy_cnt_q;
  logic [CNT_W-1:0]  busy_cnt_d;

  logic wr_ok;
  logic al_ok;
  logic same;
  logic inc;
  logic dec;
  logic rs_hit;
  logic rt_hit;

  assign wr_ok = wr_en && (wr_addr != '0);
  assign al_ok = alloc_en && (alloc_addr != '0);
  assign same  = al_ok && (alloc_addr == wr_addr);

  // count moves only on real 0->1 / 1->0 transitions
  assign inc = al_ok && !busy_q[alloc_addr];
  assign dec = wr_ok && busy_q[wr_addr] && !same;

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < DEPTH; i++) begin
      if (al_ok && alloc_addr == ADDR_W'(i)) begin
        busy_d[i] = 1'b1;
      end else if (wr_ok && wr_addr == ADDR_W'(i)) begin
        busy_d[i] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (inc && !dec) begin
      busy_cnt_d = busy_cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      busy_cnt_d = busy_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign rs_hit = wr_en && (wr_addr == rs_addr);
  assign rt_hit = wr_en && (wr_addr == rt_addr);

  assign rs_data = (rs_addr == '0) ? '0 :
                   rs_hit ? wr_data : regs_q[rs_addr];
  assign rt_data = (rt_addr == '0) ? '0 :
                   rt_hit ? wr_data : regs_q[rt_addr];

  assign rs_busy  = busy_q[rs_addr] && !rs_hit;
  assign rt_busy  = busy_q[rt_addr] && !rt_hit;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: reset, write/read, bypass,
// scoreboard lifecycle, count bounds and mid-operation reset.
module tb_reg_file_wb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic        rs_busy;
  logic        rt_busy;
  logic [5:0]  busy_cnt;

  int checks = 0;
  int errors = 0;

  reg_file_wb #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .rs_busy    (rs_busy),
    .rt_busy    (rt_busy),
    .busy_cnt   (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = 1'b0;
    alloc_en = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    rs_addr    = 5'd5;
    rt_addr    = 5'd31;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
    #2;
    chk("rst_rs_data", rs_data, 32'h0);
    chk("rst_rt_data", rt_data, 32'h0);
    chk("rst_cnt", 32'(busy_cnt), 32'd0);
    chk("rst_rs_busy", 32'(rs_busy), 32'd0);
    chk("rst_rt_busy", 32'(rt_busy), 32'd0);
    #10;
    rst_n = 1'b1;
    tick();
    chk("post_rst_rs", rs_data, 32'h0);

    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
    tick();
    wr_addr = 5'd0; wr_data = 32'h12345678; rt_addr = 5'd0;
    #1;
    chk("r0_no_bypass", rt_data, 32'h0);
    tick();
    idle();
    rs_addr = 5'd7; rt_addr = 5'd0;
    #1;
    chk("r7_read", rs_data, 32'hDEADBEEF);
    chk("r0_read", rt_data, 32'h0);
    chk("wr_cnt", 32'(busy_cnt), 32'd0);

    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1;
    tick();
    idle();
    rs_addr = 5'd9;
    #1;
    chk("r9_init", rs_data, 32'h1);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
    #1;
    chk("r9_bypass", rs_data, 32'hA5A5A5A5);
    tick();
    idle();
    #1;
    chk("r9_stored", rs_data, 32'hA5A5A5A5);

    alloc_en = 1'b1; alloc_addr = 5'd3; rs_addr = 5'd3;
    #1;
    chk("no_fwd_busy", 32'(rs_busy), 32'd0);
    tick();
    idle();
    #1;
    chk("r3_busy", 32'(rs_busy), 32'd1);
    chk("r3_cnt", 32'(busy_cnt), 32'd1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    #1;
    chk("r3_commit_busy", 32'(rs_busy), 32'd0);
    chk("r3_commit_data", rs_data, 32'h55);
    tick();
    idle();
    #1;
    chk("r3_done_cnt", 32'(busy_cnt), 32'd0);
    chk("r3_done_busy", 32'(rs_busy), 32'd0);

    alloc_en = 1'b1; alloc_addr = 5'd4;
    tick();
    idle();
    alloc_en = 1'b1; alloc_addr = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h77;
    tick();
    idle();
    rs_addr = 5'd4; rt_addr = 5'd4;
    #1;
    chk("r4_data", rs_data, 32'h77);
    chk("r4_rs_busy", 32'(rs_busy), 32'd1);
    chk("r4_rt_busy", 32'(rt_busy), 32'd1);
    chk("r4_cnt", 32'(busy_cnt), 32'd1);

    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hCAFE;
    tick();
    idle();
    rs_addr = 5'd10;
    #1;
    chk("idle_commit_cnt", 32'(busy_cnt), 32'd1);
    chk("idle_commit_data", rs_data, 32'hCAFE);

    alloc_en = 1'b1; alloc_addr = 5'd0;
    tick();
    chk("r0_alloc_cnt", 32'(busy_cnt), 32'd1);
    for (int i = 1; i < 32; i++) begin
      alloc_addr = 5'(i);
      tick();
    end
    alloc_addr = 5'd5;
    tick();
    idle();
    rs_addr = 5'd0; rt_addr = 5'd31;
    #1;
    chk("full_cnt", 32'(busy_cnt), 32'd31);
    chk("r31_busy", 32'(rt_busy), 32'd1);
    chk("r0_busy", 32'(rs_busy), 32'd0);

    #2;
    rst_n = 1'b0;
    rs_addr = 5'd7; rt_addr = 5'd31;
    #1;
    chk("mid_rst_cnt", 32'(busy_cnt), 32'd0);
    chk("mid_rst_r7", rs_data, 32'h0);
    chk("mid_rst_busy", 32'(rt_busy), 32'd0);
    for (int i = 1; i < 32; i += 6) begin
      rs_addr = 5'(i);
      #1;
      chk("mid_rst_reg", rs_data, 32'h0);
    end
    alloc_en = 1'b1; alloc_addr = 5'd6;
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hBAD0BAD0;
    tick();
    idle();
    rst_n = 1'b1;
    rs_addr = 5'd8; rt_addr = 5'd6;
    #1;
    chk("lost_wr", rs_data, 32'h0);
    chk("lost_alloc", 32'(rt_busy), 32'd0);
    chk("lost_cnt", 32'(busy_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
